oam_line_scan: RTL and testbench
================================

Name: oam_line_scan

Overview:
- OAM search stage (PPU mode 2), directly upstream of the pixel fetcher / sprite mixer.
- On each line start, walks all OAM entries in index order and selects the first MAX_LINE_SPRITES sprites whose vertical extent covers the current LY.
- Holds the selected attributes in a small line buffer. The fetcher reads that buffer during mode 3.
- Paced at 2 cycles per entry, so a full scan is 80 cycles.

Parameters:
- NUM_SPRITES, 40, OAM entries scanned per line.
- MAX_LINE_SPRITES, 10, maximum sprites kept per line.
- SPRITE_Y_OFFSET, 16, screen-to-OAM Y bias.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a scan for line_y.
- abort  in  1  abandons the scan (LCD disabled); returns to IDLE.
- line_y  in  8  current LY; sampled on start.
- sprite_size  in  1  LCDC SpriteSize; 1 = 8x16, 0 = 8x8; sampled on start.
- oam_rd  out  1  OAM read strobe.
- oam_addr  out  6  OAM entry index.
- oam_rdata  in  32  entry data, valid the cycle after oam_rd. Byte order: [31:24] YPosition, [23:16] XPosition, [15:8] Tile, [7:0] Flags.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when the scan completes.
- sprite_count  out  4  number of valid buffer entries.
- rd_index  in  4  buffer read index (combinational read).
- rd_attr  out  32  SpriteAttributes at rd_index; zero if rd_index >= sprite_count.
- rd_oam_index  out  6  OAM index of that entry; zero if invalid.

Behaviour:
- Reset (async, reset_n low):
  - state = IDLE.
  - busy, done, oam_rd, oam_addr, sprite_count = 0.
  - Buffer contents are don't-care; they are masked by sprite_count.
- States and transitions:
  - IDLE: on start, latch line_y and sprite_size, idx = 0, sprite_count = 0, go to ADDR.
  - ADDR: oam_rd = 1, oam_addr = idx, go to EVAL.
  - EVAL: evaluate oam_rdata.
    - If idx == NUM_SPRITES-1, go to DONE; otherwise idx++ and go to ADDR.
  - DONE: done = 1 for one cycle, go to IDLE.
- Timing:
  - start is sampled at edge E0.
  - Entry i is in ADDR in cycle 2i+1 and in EVAL in cycle 2i+2.
  - busy is high in cycles 1..80; done is high in cycle 81.
  - Total latency from start to done is 81 cycles.
- Hit rule, 9-bit unsigned arithmetic:
  - h = sprite_size ? 16 : 8.
  - Hit when (line_y + SPRITE_Y_OFFSET) >= Y and (line_y + SPRITE_Y_OFFSET) < (Y + h).
  - X is not checked. X = 0 or X >= 168 sprites still consume a slot.
- Store:
  - On a hit while sprite_count < MAX_LINE_SPRITES, buffer[sprite_count] = {oam_rdata, idx} and sprite_count++.
  - Hits beyond the limit are discarded; the scan still runs to entry 39.
- Buffer order is ascending OAM index. Entry 0 is the lowest-indexed hit.
- sprite_count updates live during the scan. The consumer samples the buffer only after done.
- The buffer and sprite_count hold their values until the next start.
- start while busy: restarts immediately. Latch new inputs, idx = 0, sprite_count = 0, go to ADDR. No done pulse for the abandoned scan.
- abort (priority over start in the same cycle): go to IDLE next cycle and sprite_count = 0. No done pulse. abort in IDLE only clears sprite_count.
- line_y and sprite_size changing mid-scan have no effect, because the latched copies are used.
- Reset asserted mid-scan: outputs return to reset values asynchronously.

Decomposition:
- video_types package additions:
  - localparams MAX_LINE_SPRITES = 10 and SPRITE_Y_OFFSET = 16.
  - typedef LineSprite: struct packed of SpriteAttributes attr and bit [5:0] OamIndex.
  - typedef LineSpriteBuffer: LineSprite [0:MAX_LINE_SPRITES-1].
  - enum OamScanState: IDLE, ADDR, EVAL, DONE.
- Sub-module oam_sprite_match: purely combinational.
  - Inputs: Y, line_y, sprite_size.
  - Output: hit.
  - It is reused later by the sprite mixer for row-within-sprite computation.

Test Plan:
- Single hit:
  - Stimulus: OAM[5].Y = 16, line_y = 0, 8x8, all other Y = 0.
  - Response: done in cycle 81, sprite_count = 1, rd_index 0 gives rd_oam_index = 5 and rd_attr = OAM[5].
- Overflow:
  - Stimulus: all 40 entries Y = 20, line_y = 4.
  - Response: sprite_count = 10, rd_oam_index 0..9 in order, rd_index 10 returns 0.
- Height boundary:
  - Stimulus: Y = 16, line_y = 8.
  - Response: 8x8 gives no hit (count 0); 8x16 gives a hit (count 1). line_y = 15 with 8x16 hits; line_y = 16 does not.
- Wrap/edge:
  - Stimulus: Y = 0 with line_y = 0, and Y = 160 with line_y = 143, 8x8.
  - Response: both give no hit. Y = 159 with line_y = 143 hits (159 <= 159 < 167).
- Restart and abort:
  - Stimulus: start, then start again at cycle 30 with a different line_y.
  - Response: exactly one done, 81 cycles after the second start, with a result for the second line_y.
  - Stimulus: abort at cycle 40.
  - Response: busy = 0 next cycle, no done, sprite_count = 0.
- Async reset mid-scan:
  - Stimulus: reset_n low at cycle 25.
  - Response: busy, oam_rd, sprite_count = 0 immediately. A new start after release completes normally.

Source files
------------

// File: rtl/oam_line_scan_pkg.sv
// Shared types and constants for the PPU OAM search stage and the sprite mixer.
package oam_line_scan_pkg;

  localparam int NUM_SPRITES      = 40;
  localparam int MAX_LINE_SPRITES = 10;
  localparam int SPRITE_Y_OFFSET  = 16;

  typedef struct packed {
    logic [7:0] YPosition;
    logic [7:0] XPosition;
    logic [7:0] Tile;
    logic [7:0] Flags;
  } SpriteAttributes;

  typedef struct packed {
    SpriteAttributes attr;
    logic [5:0]      OamIndex;
  } LineSprite;

  typedef LineSprite LineSpriteBuffer [0:MAX_LINE_SPRITES-1];

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    EVAL,
    DONE
  } OamScanState;

endpackage

// File: rtl/oam_sprite_match.sv
// Vertical coverage test for one sprite against a scanline.
// The mixer reuses this to locate the row within a sprite.
module oam_sprite_match
  import oam_line_scan_pkg::*;
(
  input  logic [7:0] Y,
  input  logic [7:0] line_y,
  input  logic       sprite_size,
  output logic       hit
);

  logic [8:0] w_line_top;
  logic [8:0] w_y_start;
  logic [8:0] w_y_end;

  // Nine bits keep line_y + 16 and Y + 16 from wrapping.
  assign w_line_top = {1'b0, line_y} + 9'(SPRITE_Y_OFFSET);
  assign w_y_start  = {1'b0, Y};
  assign w_y_end    = w_y_start + (sprite_size ? 9'd16 : 9'd8);

  assign hit = (w_line_top >= w_y_start) && (w_line_top < w_y_end);

endmodule

// File: rtl/oam_line_scan.sv
// OAM search (mode 2): scans all entries at two cycles each and keeps the
// first MAX_LINE_SPRITES sprites that cover the latched line.
module oam_line_scan
  import oam_line_scan_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  line_y,
  input  logic        sprite_size,
  output logic        oam_rd,
  output logic [5:0]  oam_addr,
  input  logic [31:0] oam_rdata,
  output logic        busy,
  output logic        done,
  output logic [3:0]  sprite_count,
  input  logic [3:0]  rd_index,
  output logic [31:0] rd_attr,
  output logic [5:0]  rd_oam_index
);

  OamScanState     r_state;
  OamScanState     w_next_state;
  logic [5:0]      r_idx;
  logic [7:0]      r_line_y;
  logic            r_sprite_size;
  logic [3:0]      r_count;
  LineSpriteBuffer r_buf;

  logic w_hit;
  logic w_last;
  logic w_store;
  logic w_rd_valid;

  oam_sprite_match u_match (
    .Y           (oam_rdata[31:24]),
    .line_y      (r_line_y),
    .sprite_size (r_sprite_size),
    .hit         (w_hit)
  );

  assign w_last  = (r_idx == 6'(NUM_SPRITES - 1));
  assign w_store = (r_state == EVAL) && w_hit && !abort && !start &&
                   (r_count < 4'(MAX_LINE_SPRITES));

  // abort wins over start; start restarts from any state.
  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = IDLE;
    end else if (start) begin
      w_next_state = ADDR;
    end else begin
      case (r_state)
        IDLE:    w_next_state = IDLE;
        ADDR:    w_next_state = EVAL;
        EVAL:    w_next_state = w_last ? DONE : ADDR;
        DONE:    w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx         <= '0;
      r_line_y      <= '0;
      r_sprite_size <= 1'b0;
      r_count       <= '0;
    end else if (abort) begin
      r_count <= '0;
    end else if (start) begin
      r_idx         <= '0;
      r_line_y      <= line_y;
      r_sprite_size <= sprite_size;
      r_count       <= '0;
    end else if (r_state == EVAL) begin
      if (w_store) begin
        r_count <= r_count + 4'd1;
      end
      if (!w_last) begin
        r_idx <= r_idx + 6'd1;
      end
    end
  end

  // Buffer needs no reset: unused slots are hidden behind r_count.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_buf[r_count] <= {oam_rdata, r_idx};
    end
  end

  assign oam_rd       = (r_state == ADDR);
  assign oam_addr     = (r_state == ADDR) ? r_idx : 6'd0;
  assign busy         = (r_state == ADDR) || (r_state == EVAL);
  assign done         = (r_state == DONE);
  assign sprite_count = r_count;

  assign w_rd_valid   = (rd_index < r_count);
  assign rd_attr      = w_rd_valid ? r_buf[rd_index].attr : 32'd0;
  assign rd_oam_index = w_rd_valid ? r_buf[rd_index].OamIndex : 6'd0;

endmodule

// File: tb/tb_oam_line_scan.sv
// Self-checking bench for oam_line_scan: directed corner cases plus random
// OAM contents compared against a line-selection reference model.
module tb_oam_line_scan;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [7:0]  line_y;
  logic        sprite_size;
  logic        oam_rd;
  logic [5:0]  oam_addr;
  logic [31:0] oam_rdata = 32'd0;
  logic        busy;
  logic        done;
  logic [3:0]  sprite_count;
  logic [3:0]  rd_index;
  logic [31:0] rd_attr;
  logic [5:0]  rd_oam_index;

  logic [31:0] oamMem [0:39];
  int          nVectors = 0;
  int          nMiscompares = 0;
  int          expCount;
  logic [31:0] expAttr [0:9];
  int          expIdx [0:9];
  int          doneCycle;
  int          doneCount;
  int          earlyDone;

  oam_line_scan dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .line_y       (line_y),
    .sprite_size  (sprite_size),
    .oam_rd       (oam_rd),
    .oam_addr     (oam_addr),
    .oam_rdata    (oam_rdata),
    .busy         (busy),
    .done         (done),
    .sprite_count (sprite_count),
    .rd_index     (rd_index),
    .rd_attr      (rd_attr),
    .rd_oam_index (rd_oam_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (oam_rd) oam_rdata <= oamMem[oam_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nVectors++;
    assert (observed === expected) else begin
      nMiscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: walk OAM in index order, keep the first ten entries whose rows cover the line.
  function automatic void modelScan(input int ly, input bit tall);
    int screenRow = ly + 16;
    int height = tall ? 16 : 8;
    expCount = 0;
    for (int i = 0; i < 40; i++) begin
      int y = int'(oamMem[i][31:24]);
      if (screenRow >= y && screenRow < y + height && expCount < 10) begin
        expAttr[expCount] = oamMem[i];
        expIdx[expCount]  = i;
        expCount++;
      end
    end
  endfunction

  task automatic fillAll(input int yval);
    logic [31:0] tmp;
    for (int i = 0; i < 40; i++) begin
      tmp = $urandom();
      oamMem[i] = {8'(yval), tmp[23:0]};
    end
  endtask

  // Called at a falling edge; leaves the bench at the falling edge of cycle 1.
  task automatic applyStimulus(input logic [7:0] ly, input logic tall);
    line_y      = ly;
    sprite_size = tall;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    line_y      = 8'($urandom());
    sprite_size = 1'($urandom());
  endtask

  task automatic waitDone(input bit checkProto, output int dCycle, output int dCount);
    dCycle = -1;
    dCount = 0;
    for (int c = 1; c <= 200; c++) begin
      if (checkProto && c <= 80) begin
        checkOutput($sformatf("busy_c%0d", c), 32'(busy), 32'd1);
        checkOutput($sformatf("oam_rd_c%0d", c), 32'(oam_rd), 32'(c % 2));
        if (c % 2 == 1)
          checkOutput($sformatf("oam_addr_c%0d", c), 32'(oam_addr), 32'((c - 1) / 2));
      end
      if (done) begin
        dCount++;
        if (dCycle < 0) dCycle = c;
      end
      if (dCycle >= 0 && c >= dCycle + 3) break;
      @(negedge clk);
    end
  endtask

  task automatic checkBuffer(input string tag);
    checkOutput({tag, "_count"}, 32'(sprite_count), 32'(expCount));
    for (int i = 0; i < 16; i++) begin
      rd_index = 4'(i);
      #1;
      if (i < expCount) begin
        checkOutput($sformatf("%s_attr%0d", tag, i), rd_attr, expAttr[i]);
        checkOutput($sformatf("%s_idx%0d", tag, i), 32'(rd_oam_index), 32'(expIdx[i]));
      end else begin
        checkOutput($sformatf("%s_attr%0d", tag, i), rd_attr, 32'd0);
        checkOutput($sformatf("%s_idx%0d", tag, i), 32'(rd_oam_index), 32'd0);
      end
    end
    @(negedge clk);
  endtask

  task automatic runScan(input string tag, input logic [7:0] ly, input logic tall);
    applyStimulus(ly, tall);
    waitDone(1'b1, doneCycle, doneCount);
    checkOutput({tag, "_latency"}, 32'(doneCycle), 32'd81);
    checkOutput({tag, "_done_pulses"}, 32'(doneCount), 32'd1);
    modelScan(int'(ly), tall);
    checkBuffer(tag);
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    line_y      = 8'd0;
    sprite_size = 1'b0;
    rd_index    = 4'd0;
    #12;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_oam_rd", 32'(oam_rd), 32'd0);
    checkOutput("rst_oam_addr", 32'(oam_addr), 32'd0);
    checkOutput("rst_count", 32'(sprite_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Single hit at entry 5.
    fillAll(0);
    oamMem[5][31:24] = 8'd16;
    runScan("single", 8'd0, 1'b0);
    checkOutput("single_const_count", 32'(sprite_count), 32'd1);
    rd_index = 4'd0;
    #1;
    checkOutput("single_const_idx", 32'(rd_oam_index), 32'd5);
    checkOutput("single_const_attr", rd_attr, oamMem[5]);
    @(negedge clk);

    // Overflow: every entry hits, only the first ten are kept.
    fillAll(20);
    runScan("ovf", 8'd4, 1'b0);
    checkOutput("ovf_const_count", 32'(sprite_count), 32'd10);
    rd_index = 4'd10;
    #1;
    checkOutput("ovf_idx10_attr", rd_attr, 32'd0);
    checkOutput("ovf_idx10_oam", 32'(rd_oam_index), 32'd0);
    @(negedge clk);

    // abort while idle only clears the count.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("idle_abort_count", 32'(sprite_count), 32'd0);
    checkOutput("idle_abort_busy", 32'(busy), 32'd0);

    // Height boundaries.
    fillAll(0);
    oamMem[7][31:24] = 8'd16;
    runScan("h8_ly8", 8'd8, 1'b0);
    checkOutput("h8_ly8_const", 32'(sprite_count), 32'd0);
    runScan("h16_ly8", 8'd8, 1'b1);
    checkOutput("h16_ly8_const", 32'(sprite_count), 32'd1);
    runScan("h16_ly15", 8'd15, 1'b1);
    checkOutput("h16_ly15_const", 32'(sprite_count), 32'd1);
    runScan("h16_ly16", 8'd16, 1'b1);
    checkOutput("h16_ly16_const", 32'(sprite_count), 32'd0);

    // Edge Y values.
    fillAll(0);
    runScan("y0_ly0", 8'd0, 1'b0);
    checkOutput("y0_ly0_const", 32'(sprite_count), 32'd0);
    oamMem[12][31:24] = 8'd160;
    runScan("y160_ly143", 8'd143, 1'b0);
    checkOutput("y160_ly143_const", 32'(sprite_count), 32'd0);
    oamMem[12][31:24] = 8'd159;
    runScan("y159_ly143", 8'd143, 1'b0);
    checkOutput("y159_ly143_const", 32'(sprite_count), 32'd1);

    // Restart at cycle 30 with a different line.
    for (int i = 0; i < 40; i++) oamMem[i] = $urandom();
    for (int i = 0; i < 40; i++) oamMem[i][31:24] = 8'(50 + $urandom_range(0, 70));
    earlyDone = 0;
    applyStimulus(8'd50, 1'b1);
    for (int k = 2; k <= 29; k++) begin
      @(negedge clk);
      if (done) earlyDone++;
    end
    applyStimulus(8'd90, 1'b0);
    waitDone(1'b1, doneCycle, doneCount);
    checkOutput("restart_early_done", 32'(earlyDone), 32'd0);
    checkOutput("restart_latency", 32'(doneCycle), 32'd81);
    checkOutput("restart_done_pulses", 32'(doneCount), 32'd1);
    modelScan(90, 1'b0);
    checkBuffer("restart");

    // Abort at cycle 40.
    fillAll(20);
    applyStimulus(8'd4, 1'b0);
    for (int k = 2; k <= 40; k++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_count", 32'(sprite_count), 32'd0);
    waitDone(1'b0, doneCycle, doneCount);
    checkOutput("abort_done_pulses", 32'(doneCount), 32'd0);
    expCount = 0;
    checkBuffer("abort");

    // Async reset at cycle 25, then a clean scan.
    for (int i = 0; i < 40; i++) oamMem[i] = $urandom();
    for (int i = 0; i < 40; i++) oamMem[i][31:24] = 8'(60 + $urandom_range(0, 30));
    applyStimulus(8'd60, 1'b0);
    for (int k = 2; k <= 25; k++) @(negedge clk);
    checkOutput("pre_reset_rd", 32'(oam_rd), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_reset_busy", 32'(busy), 32'd0);
    checkOutput("mid_reset_rd", 32'(oam_rd), 32'd0);
    checkOutput("mid_reset_count", 32'(sprite_count), 32'd0);
    checkOutput("mid_reset_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    runScan("post_reset", 8'd60, 1'b0);

    // Random OAM contents clustered around the line.
    for (int t = 0; t < 10; t++) begin
      int ly;
      logic tall;
      ly   = int'($urandom_range(0, 153));
      tall = 1'($urandom());
      for (int i = 0; i < 40; i++) oamMem[i] = $urandom();
      for (int i = 0; i < 40; i++) oamMem[i][31:24] = 8'(ly + int'($urandom_range(0, 40)));
      runScan($sformatf("rand%0d", t), 8'(ly), tall);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
